wb_writer: RTL

Write-back stage driving the single GPR write port (`rd_we_o`/`rd_wa_o`/`rd_wd_o` into the register file, whose read ports forward this same cycle's write). Merges in-order results from the LSU/MEM pipeline register with out-of-order results from long-latency units (divider) through a small late-result FIFO. Pipeline results have priority; an optional starvation guard stalls the pipe so queued late results drain.

---
 rtl/wb_writer_pkg.sv | 28 ++
 rtl/wb_writer_late_fifo.sv | 64 ++++++
 rtl/wb_writer.sv | 110 +++++++++++
 3 files changed

// File: rtl/wb_writer_pkg.sv
// Shared types and widths for the write-back stage; widths mirror the core's
// shared register-bus defines (32 GPRs, 32-bit data).
package wb_writer_pkg;

  localparam int REG_NUM_LOG2 = 5;
  localparam int REG_AW       = REG_NUM_LOG2;
  localparam int REG_DW       = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [REG_DW-1:0] reg_data_t;

  localparam reg_data_t ZERO_WORD    = '0;
  localparam logic      WRITE_ENABLE = 1'b1;

  // One GPR write request as held in the late-result FIFO.
  typedef struct packed {
    reg_addr_t wa;
    reg_data_t wd;
  } wb_req_t;

  // Owner of the single write port in a given cycle.
  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_PIPE,
    WIN_FIFO
  } win_e;

endpackage

// File: rtl/wb_writer_late_fifo.sv
// Late-result FIFO: circular storage, wrapping pointers, occupancy count and
// a pending-write address match for the issue scoreboard.
module wb_late_fifo
  import wb_writer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      ck_i,
  input  logic      rs_n_i,
  input  logic      push,
  input  wb_req_t   push_req,
  input  logic      pop,
  output wb_req_t   head,
  output logic      rdy,
  output logic      empty,
  input  reg_addr_t chk_a,
  output logic      hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_req_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [DEPTH-1:0] match;

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; count alone defines which slots are valid.
  always_ff @(posedge ck_i) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  // A slot is live when its distance from the read pointer is below count.
  // NOTE: match is fully assigned before the loop so no latch is inferred.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = (CW'(PW'(i) - rd_ptr) < count) && (mem[i].wa == chk_a);
    end
  end

  assign head  = mem[rd_ptr];
  assign rdy   = (count < CW'(DEPTH));
  assign empty = (count == '0);
  assign hit   = (|match) && (chk_a != '0);

endmodule

// File: rtl/wb_writer.sv
// Write-back stage: arbitrates the single GPR write port between in-order pipe
// results and queued late results. Optional starvation guard: WB_STARVE_GUARD_EN.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 8
) (
  input  logic      ck_i,
  input  logic      rs_n_i,
  input  logic      pipe_vld_i,
  input  logic      pipe_we_i,
  input  reg_addr_t pipe_wa_i,
  input  reg_data_t pipe_wd_i,
  input  logic      late_vld_i,
  output logic      late_rdy_o,
  input  reg_addr_t late_wa_i,
  input  reg_data_t late_wd_i,
  input  reg_addr_t pend_chk_a_i,
  output logic      pend_hit_o,
  output logic      wb_stall_o,
  output logic      rd_we_o,
  output reg_addr_t rd_wa_o,
  output reg_data_t rd_wd_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIM < 1) begin : g_bad_cfg
    $error("wb_writer: FIFO_DEPTH must be a power of two >= 2, STARVE_LIM >= 1");
  end

  logic    pipe_acc;
  logic    fifo_empty;
  logic    push;
  logic    pop;
  logic    stall_q;
  wb_req_t head;
  win_e    win;

  assign pipe_acc = pipe_vld_i & pipe_we_i & (pipe_wa_i != '0);
  assign push     = late_vld_i & late_rdy_o;
  assign pop      = (win == WIN_FIFO);

  wb_late_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .ck_i     (ck_i),
    .rs_n_i   (rs_n_i),
    .push     (push),
    .push_req ({late_wa_i, late_wd_i}),
    .pop      (pop),
    .head     (head),
    .rdy      (late_rdy_o),
    .empty    (fifo_empty),
    .chk_a    (pend_chk_a_i),
    .hit      (pend_hit_o)
  );

  // Stall mode hands the slot to the FIFO even if a pipe write slipped in.
  always_comb begin
    win = WIN_NONE;
    if (stall_q && !fifo_empty) win = WIN_FIFO;
    else if (pipe_acc)          win = WIN_PIPE;
    else if (!fifo_empty)       win = WIN_FIFO;
  end

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      rd_we_o <= 1'b0;
      rd_wa_o <= '0;
      rd_wd_o <= ZERO_WORD;
    end else begin
      case (win)
        WIN_PIPE: begin
          rd_we_o <= WRITE_ENABLE;
          rd_wa_o <= pipe_wa_i;
          rd_wd_o <= pipe_wd_i;
        end
        WIN_FIFO: begin
          // x0-destined late results drain silently.
          rd_we_o <= (head.wa != '0);
          rd_wa_o <= head.wa;
          rd_wd_o <= head.wd;
        end
        default: rd_we_o <= 1'b0;
      endcase
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [SW-1:0] starve_cnt;

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (pop || fifo_empty)                 starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIM)) starve_cnt <= starve_cnt + 1'b1;

      if (pop)                               stall_q <= 1'b0;
      else if (starve_cnt == SW'(STARVE_LIM)) stall_q <= 1'b1;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  assign wb_stall_o = stall_q;

endmodule
